// File: rtl/alu_seq_ctrl.sv
// ALU control sequencer: single-cycle decode, multi-step shifts, optional multiply.
// Define ALU_SEQ_MULT_EN to give funct 0x19 a multi-cycle MULT state.
module alu_seq_ctrl #(
    parameter int CTRL_W      = 6,
    parameter int SHAMT_W     = 5,
    parameter int MULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [5:0]         functionCode,
    input  logic [4:0]         ALUop,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [CTRL_W-1:0]  ALUctrl,
    output logic               alu_valid,
    output logic               feedback,
    output logic               stall,
    output logic               done
);

`ifdef ALU_SEQ_MULT_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MULT} state_t;
    logic [3:0] cnt_q, cnt_n;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state_q, state_n;
    logic [5:0]         funct_q, funct_n;
    logic [SHAMT_W-1:0] rem_q, rem_n, step;
    logic [CTRL_W-1:0]  ctrl_n;
    logic               valid_n, fb_n, stall_n, done_n, shift_op;

    // Largest step first: 8, then 2, then 1.
    function automatic logic [SHAMT_W-1:0] step_of(input logic [SHAMT_W-1:0] r);
        if (int'(r) >= 8) return SHAMT_W'(8);
        if (int'(r) >= 2) return SHAMT_W'(2);
        return SHAMT_W'(1);
    endfunction

    function automatic logic [CTRL_W-1:0] step_code(input logic [5:0] fn,
                                                    input logic [SHAMT_W-1:0] st);
        logic [7:0] base, off;
        base = (fn == 6'h00) ? 8'h0A : (fn == 6'h02) ? 8'h0D : 8'h10;
        off  = (int'(st) == 8) ? 8'd2 : (int'(st) == 2) ? 8'd1 : 8'd0;
        return CTRL_W'(base + off);
    endfunction

    function automatic logic [CTRL_W-1:0] decode(input logic [4:0] op,
                                                 input logic [5:0] fn);
        logic [7:0] c;
        c = 8'h00;
        case (op)
            5'd0: c = 8'h02;
            5'd1: c = 8'h06;
            5'd2: begin
                case (fn)
                    6'h20:   c = 8'h02;
                    6'h21:   c = 8'h03;
                    6'h23:   c = 8'h06;
                    6'h25:   c = 8'h01;
                    6'h26:   c = 8'h04;
                    6'h2A:   c = 8'h07;
                    6'h2B:   c = 8'h08;
                    6'h30:   c = 8'h14;
                    6'h19:   c = 8'h13;
                    default: c = 8'h00;
                endcase
            end
            5'd3: c = 8'h03;
            5'd5: c = 8'h01;
            5'd6: c = 8'h04;
            5'd7: c = 8'h07;
            5'd8: c = 8'h08;
            5'd9: c = 8'h09;
            default: c = 8'h00;
        endcase
        return CTRL_W'(c);
    endfunction

    assign shift_op = (ALUop == 5'd2) &&
                      (functionCode == 6'h00 || functionCode == 6'h02 ||
                       functionCode == 6'h03);

    always_comb begin
        state_n = IDLE;
        funct_n = funct_q;
        rem_n   = rem_q;
        step    = '0;
        ctrl_n  = '0;
        valid_n = 1'b0;
        fb_n    = 1'b0;
        stall_n = 1'b0;
        done_n  = 1'b0;
`ifdef ALU_SEQ_MULT_EN
        cnt_n   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_in && !stall) begin
                    valid_n = 1'b1;
                    if (shift_op && Shamt != '0) begin
                        step    = step_of(Shamt);
                        ctrl_n  = step_code(functionCode, step);
                        funct_n = functionCode;
                        rem_n   = Shamt - step;
                        if (rem_n != '0) begin
                            stall_n = 1'b1;
                            state_n = SHIFT;
                        end else begin
                            done_n = 1'b1;
                        end
                    end
`ifdef ALU_SEQ_MULT_EN
                    else if (ALUop == 5'd2 && functionCode == 6'h19) begin
                        ctrl_n  = CTRL_W'(8'h13);
                        cnt_n   = 4'(MULT_CYCLES - 1);
                        stall_n = 1'b1;
                        state_n = MULT;
                    end
`endif
                    else begin
                        ctrl_n = decode(ALUop, functionCode);
                        done_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                step    = step_of(rem_q);
                ctrl_n  = step_code(funct_q, step);
                valid_n = 1'b1;
                fb_n    = 1'b1;
                rem_n   = rem_q - step;
                if (rem_n != '0) begin
                    stall_n = 1'b1;
                    state_n = SHIFT;
                end else begin
                    done_n = 1'b1;
                end
            end
`ifdef ALU_SEQ_MULT_EN
            MULT: begin
                ctrl_n  = CTRL_W'(8'h13);
                valid_n = 1'b1;
                cnt_n   = cnt_q - 4'd1;
                if (cnt_n != 4'd0) begin
                    stall_n = 1'b1;
                    state_n = MULT;
                end else begin
                    done_n = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            funct_q   <= '0;
            rem_q     <= '0;
            ALUctrl   <= '0;
            alu_valid <= 1'b0;
            feedback  <= 1'b0;
            stall     <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_n;
            funct_q   <= funct_n;
            rem_q     <= rem_n;
            ALUctrl   <= ctrl_n;
            alu_valid <= valid_n;
            feedback  <= fb_n;
            stall     <= stall_n;
            done      <= done_n;
`ifdef ALU_SEQ_MULT_EN
            cnt_q     <= cnt_n;
`endif
        end
    end

endmodule
